// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM status toward the sequencer and the
// per-stage enable/flush controls back to the pipeline registers.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_valid;
  logic [RA_W-1:0]  ex_rd;
  logic             ex_is_load;
  logic             ex_multi;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             en_pc;
  logic             en_ifid;
  logic             en_idex;
  logic             en_exmem;
  logic             en_memwb;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             busy_multi;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rd,
           ex_is_load, ex_multi, ex_br_taken, mem_req, mem_ready,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, busy_multi, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rd,
           ex_is_load, ex_multi, ex_br_taken, mem_req, mem_ready,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, busy_multi, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, branch squashes,
// multi-cycle EX occupancy, data-memory wait states and a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int RA_W      = 5,
  parameter int EX_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset_,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CW = (EX_CYCLES > 2) ? $clog2(EX_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic en_pc_s, en_ifid_s, en_idex_s, en_exmem_s, en_memwb_s;
  logic flush_ifid_s, flush_idex_s, flush_exmem_s;
  logic mem_wait_s, load_use_s;

  assign mem_wait_s = bus.mem_req & ~bus.mem_ready;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard
  assign load_use_s = bus.ex_valid & bus.ex_is_load &
                      (bus.ex_rd != {RA_W{1'b0}}) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // Prioritised enable/flush decode and next-state logic
  always_comb begin
    en_pc_s       = 1'b1;
    en_ifid_s     = 1'b1;
    en_idex_s     = 1'b1;
    en_exmem_s    = 1'b1;
    en_memwb_s    = 1'b1;
    flush_ifid_s  = 1'b0;
    flush_idex_s  = 1'b0;
    flush_exmem_s = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (!reset_) begin
      en_pc_s    = 1'b0;
      en_ifid_s  = 1'b0;
      en_idex_s  = 1'b0;
      en_exmem_s = 1'b0;
      en_memwb_s = 1'b0;
    end else if (mem_wait_s) begin
      en_pc_s    = 1'b0;
      en_ifid_s  = 1'b0;
      en_idex_s  = 1'b0;
      en_exmem_s = 1'b0;
      en_memwb_s = 1'b0;
    end else if (state_q == ST_MULTI) begin
      if (cnt_q != {CW{1'b0}}) begin
        en_pc_s       = 1'b0;
        en_ifid_s     = 1'b0;
        en_idex_s     = 1'b0;
        flush_exmem_s = 1'b1;
        cnt_d         = cnt_q - CW'(1);
      end else begin
        state_d = ST_RUN;
      end
    end else if (bus.ex_valid && bus.ex_multi) begin
      // first EX cycle of the op counts toward its occupancy, hence -2
      en_pc_s       = 1'b0;
      en_ifid_s     = 1'b0;
      en_idex_s     = 1'b0;
      flush_exmem_s = 1'b1;
      state_d       = ST_MULTI;
      cnt_d         = CW'(EX_CYCLES - 2);
    end else if (bus.ex_br_taken && !bus.ex_multi) begin
      flush_ifid_s = 1'b1;
      flush_idex_s = 1'b1;
    end else if (load_use_s) begin
      en_pc_s      = 1'b0;
      en_ifid_s    = 1'b0;
      flush_idex_s = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!en_pc_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State, countdown and stall counter registers
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q        <= ST_RUN;
      cnt_q          <= {CW{1'b0}};
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.en_pc        = en_pc_s;
  assign bus.en_ifid      = en_ifid_s;
  assign bus.en_idex      = en_idex_s;
  assign bus.en_exmem     = en_exmem_s;
  assign bus.en_memwb     = en_memwb_s;
  assign bus.flush_ifid   = flush_ifid_s;
  assign bus.flush_idex   = flush_idex_s;
  assign bus.flush_exmem  = flush_exmem_s;
  assign bus.busy_multi   = (state_q == ST_MULTI);
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against an occupancy-based reference model.
module tb_pipe_hazard_ctrl;
  localparam int RA_W      = 5;
  localparam int EX_CYCLES = 4;
  localparam int CNT_W     = 8;
  localparam int SAT       = (1 << CNT_W) - 1;

  logic clock  = 1'b0;
  logic reset_ = 1'b0;
  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.RA_W(RA_W), .EX_CYCLES(EX_CYCLES), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  typedef struct packed {
    logic            rst;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            u1;
    logic            u2;
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            load;
    logic            multi;
    logic            br;
    logic            req;
    logic            rdy;
  } stim_t;

  // en = {pc,ifid,idex,exmem,memwb}, fl = {ifid,idex,exmem}
  typedef struct packed {
    logic [4:0]       en;
    logic [2:0]       fl;
    logic             busy;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   occ_left = 0;   // remaining EX-occupancy cycles of the multi-cycle op
  int   stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic mw, lu;
    @(negedge clock);
    reset_          = s.rst;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_use_rs1  = s.u1;
    bus.id_use_rs2  = s.u2;
    bus.ex_valid    = s.valid;
    bus.ex_rd       = s.rd;
    bus.ex_is_load  = s.load;
    bus.ex_multi    = s.multi;
    bus.ex_br_taken = s.br;
    bus.mem_req     = s.req;
    bus.mem_ready   = s.rdy;
    if (!s.rst) begin
      occ_left = 0;
      stalls   = 0;
      q.push_back('0);
      return;
    end
    e      = '0;
    e.sc   = CNT_W'(stalls);
    e.busy = (occ_left > 0);
    mw = s.req && !s.rdy;
    lu = s.valid && s.load && (s.rd != 0) &&
         ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (mw) begin
      e.en = 5'b00000;
    end else if (occ_left > 1 || (occ_left == 0 && s.valid && s.multi)) begin
      e.en = 5'b00011;
      e.fl = 3'b001;
    end else if (occ_left == 1) begin
      e.en = 5'b11111;
    end else if (s.br && !s.multi) begin
      e.en = 5'b11111;
      e.fl = 3'b110;
    end else if (lu) begin
      e.en = 5'b00111;
      e.fl = 3'b010;
    end else begin
      e.en = 5'b11111;
    end
    q.push_back(e);
    if (!mw) begin
      if (occ_left > 0) occ_left--;
      else if (s.valid && s.multi) occ_left = EX_CYCLES - 1;
    end
    if (!e.en[4] && stalls < SAT) stalls++;
  endtask

  // Monitor: outputs are compared one step after the inputs settle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("en", {bus.en_pc, bus.en_ifid, bus.en_idex, bus.en_exmem, bus.en_memwb}, 32'(e.en));
        chk("flush", {bus.flush_ifid, bus.flush_idex, bus.flush_exmem}, 32'(e.fl));
        chk("busy_multi", 32'(bus.busy_multi), 32'(e.busy));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(e.sc));
      end
    end
  end

  initial begin
    stim_t s, r;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_rd = '0; bus.ex_is_load = 1'b0; bus.ex_multi = 1'b0;
    bus.ex_br_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    r = idle(); r.rst = 1'b0;

    // reset held, released at 22ns, idle afterwards
    step(r); step(r);
    #2 reset_ = 1'b1;
    step(idle()); step(idle());

    // load-use on rs2, then the same with ex_rd = x0
    step(r);
    s = idle(); s.valid = 1'b1; s.load = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
    step(s); step(idle());
    #1 chk("loaduse_stall_cnt", 32'(bus.stall_cycles), 32'd1);
    s.rd = 5'd0; s.rs2 = 5'd0;
    step(s); step(idle());
    #1 chk("x0_no_stall", 32'(bus.stall_cycles), 32'd1);

    // multi-cycle op
    step(r);
    s = idle(); s.valid = 1'b1; s.multi = 1'b1;
    for (int i = 0; i < EX_CYCLES; i++) step(s);
    step(idle());
    #1 chk("multi_stall_cnt", 32'(bus.stall_cycles), 32'd3);

    // taken branch overrides a load-use match
    step(r);
    s = idle(); s.valid = 1'b1; s.load = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1; s.br = 1'b1;
    step(s); step(idle());
    #1 chk("branch_no_stall", 32'(bus.stall_cycles), 32'd0);

    // memory wait inside a multi-cycle op freezes the countdown
    step(r);
    s = idle(); s.valid = 1'b1; s.multi = 1'b1;
    step(s); step(s);
    s.req = 1'b1;
    for (int i = 0; i < 3; i++) step(s);
    s.rdy = 1'b1;
    step(s);
    s.req = 1'b0; s.rdy = 1'b0;
    step(s); step(idle());
    #1 chk("memwait_stall_cnt", 32'(bus.stall_cycles), 32'd6);

    // asynchronous reset in the middle of a multi-cycle op
    s = idle(); s.valid = 1'b1; s.multi = 1'b1;
    step(s); step(s);
    @(posedge clock);
    #2 reset_ = 1'b0;
    #1;
    chk("async_busy", 32'(bus.busy_multi), 32'd0);
    chk("async_en_pc", 32'(bus.en_pc), 32'd0);
    occ_left = 0; stalls = 0;
    step(r);

    // saturation of the stall counter
    s = idle(); s.req = 1'b1;
    for (int i = 0; i < SAT + 40; i++) step(s);
    step(idle());
    #1 chk("stall_saturate", 32'(bus.stall_cycles), 32'(SAT));

    // randomized traffic
    step(r);
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(0, 99) != 0);
      s.rs1   = RA_W'($urandom_range(0, 3));
      s.rs2   = RA_W'($urandom_range(0, 3));
      s.u1    = 1'($urandom);
      s.u2    = 1'($urandom);
      s.valid = ($urandom_range(0, 3) != 0);
      s.rd    = RA_W'($urandom_range(0, 3));
      s.load  = 1'($urandom);
      s.multi = ($urandom_range(0, 7) == 0);
      s.br    = ($urandom_range(0, 5) == 0);
      s.req   = ($urandom_range(0, 3) == 0);
      s.rdy   = 1'($urandom);
      step(s);
    end

    repeat (3) @(negedge clock);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
